// File: rtl/sc_level_tracker.sv
// Level/progress tracker for the game controller: edge-detects the active-low
// strobes and steps a three-state IDLE/PLAY/OVER machine with level, progress and prescaler counters.
module sc_level_tracker #(
  parameter int unsigned PRESCALE_WIDTH    = 8,
  parameter int unsigned PRESCALE_TERMINAL = 100
) (
  input  logic       SC_LEVEL_STATEMACHINE_CLOCK_50,
  input  logic       SC_LEVEL_STATEMACHINE_RESET_InHigh,
  input  logic       SC_LEVEL_TRACKER_Start_InLow,
  input  logic       SC_LEVEL_TRACKER_upCount_InLow,
  input  logic       SC_LEVEL_TRACKER_ProgressUpCount_InLow,
  input  logic       SC_LEVEL_TRACKER_LevelFinished_InLow,
  input  logic       SC_LEVEL_TRACKER_FinishedGame_InLow,
  output logic [2:0] SC_LEVEL_TRACKER_CurrentLevel_Out,
  output logic [4:0] SC_LEVEL_TRACKER_LvlProgressCount_Out,
  output logic       SC_LEVEL_TRACKER_T0_OutLow,
  output logic       SC_LEVEL_TRACKER_GameOver_Out
);

  localparam logic [PRESCALE_WIDTH-1:0] LP_TERMINAL = PRESCALE_WIDTH'(PRESCALE_TERMINAL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t                    r_state;
  logic [2:0]                r_level;
  logic [4:0]                r_progress;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_start_prev;
  logic                      r_tick_prev;
  logic                      r_prog_prev;
  logic                      r_lvl_prev;
  logic                      r_fin_prev;

  logic w_start_ev;
  logic w_tick_ev;
  logic w_prog_ev;
  logic w_lvl_ev;
  logic w_fin_ev;

  // Falling edge: low now, high on the previous sample.
  assign w_start_ev = ~SC_LEVEL_TRACKER_Start_InLow           & r_start_prev;
  assign w_tick_ev  = ~SC_LEVEL_TRACKER_upCount_InLow         & r_tick_prev;
  assign w_prog_ev  = ~SC_LEVEL_TRACKER_ProgressUpCount_InLow & r_prog_prev;
  assign w_lvl_ev   = ~SC_LEVEL_TRACKER_LevelFinished_InLow   & r_lvl_prev;
  assign w_fin_ev   = ~SC_LEVEL_TRACKER_FinishedGame_InLow    & r_fin_prev;

  always_ff @(posedge SC_LEVEL_STATEMACHINE_CLOCK_50 or posedge SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
    if (SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
      r_state      <= ST_IDLE;
      r_level      <= '0;
      r_progress   <= '0;
      r_prescale   <= '0;
      r_start_prev <= 1'b1;
      r_tick_prev  <= 1'b1;
      r_prog_prev  <= 1'b1;
      r_lvl_prev   <= 1'b1;
      r_fin_prev   <= 1'b1;
    end else begin
      r_start_prev <= SC_LEVEL_TRACKER_Start_InLow;
      r_tick_prev  <= SC_LEVEL_TRACKER_upCount_InLow;
      r_prog_prev  <= SC_LEVEL_TRACKER_ProgressUpCount_InLow;
      r_lvl_prev   <= SC_LEVEL_TRACKER_LevelFinished_InLow;
      r_fin_prev   <= SC_LEVEL_TRACKER_FinishedGame_InLow;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ev) begin
            r_level    <= 3'd1;
            r_progress <= '0;
            r_prescale <= '0;
            r_state    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          // Priority chain discards lower-priority events in the same cycle.
          if (w_fin_ev) begin
            r_state <= ST_OVER;
          end else if (w_lvl_ev) begin
            if (r_level != 3'd7) r_level <= r_level + 3'd1;
            r_progress <= '0;
            r_prescale <= '0;
          end else if (w_prog_ev) begin
            if (r_progress != 5'd31) r_progress <= r_progress + 5'd1;
            r_prescale <= '0;
          end else if (w_tick_ev) begin
            if (r_prescale < LP_TERMINAL) r_prescale <= r_prescale + 1'b1;
          end
        end
        ST_OVER: begin
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign SC_LEVEL_TRACKER_CurrentLevel_Out      = r_level;
  assign SC_LEVEL_TRACKER_LvlProgressCount_Out  = r_progress;
  assign SC_LEVEL_TRACKER_T0_OutLow             = ~((r_state == ST_PLAY) && (r_prescale == LP_TERMINAL));
  assign SC_LEVEL_TRACKER_GameOver_Out          = (r_state == ST_OVER);

endmodule

// File: tb/tb_sc_level_tracker.sv
// Directed bench for sc_level_tracker with a prescaler terminal of 4.
module tb_sc_level_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] stb = '1;   // {fin, lvl, prog, tick, start}, active low
  logic [2:0] level;
  logic [4:0] prog;
  logic       t0_n;
  logic       game_over;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [4:0] M_START = 5'b00001;
  localparam logic [4:0] M_TICK  = 5'b00010;
  localparam logic [4:0] M_PROG  = 5'b00100;
  localparam logic [4:0] M_LVL   = 5'b01000;
  localparam logic [4:0] M_FIN   = 5'b10000;

  always #5 clk = ~clk;

  sc_level_tracker #(
    .PRESCALE_WIDTH(8),
    .PRESCALE_TERMINAL(4)
  ) dut (
    .SC_LEVEL_STATEMACHINE_CLOCK_50         (clk),
    .SC_LEVEL_STATEMACHINE_RESET_InHigh     (rst),
    .SC_LEVEL_TRACKER_Start_InLow           (stb[0]),
    .SC_LEVEL_TRACKER_upCount_InLow         (stb[1]),
    .SC_LEVEL_TRACKER_ProgressUpCount_InLow (stb[2]),
    .SC_LEVEL_TRACKER_LevelFinished_InLow   (stb[3]),
    .SC_LEVEL_TRACKER_FinishedGame_InLow    (stb[4]),
    .SC_LEVEL_TRACKER_CurrentLevel_Out      (level),
    .SC_LEVEL_TRACKER_LvlProgressCount_Out  (prog),
    .SC_LEVEL_TRACKER_T0_OutLow             (t0_n),
    .SC_LEVEL_TRACKER_GameOver_Out          (game_over)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle low pulse on the masked strobes, followed by one idle-high cycle.
  task automatic pulse(input logic [4:0] mask);
    stb = ~mask;
    step();
    stb = '1;
    step();
  endtask

  task automatic pulses(input logic [4:0] mask, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) pulse(mask);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (prog !== 5'd0) begin n_bad++; $display("FAIL reset_prog got %0d want 0", prog); end
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL reset_t0 got %b want 1", t0_n); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_gameover got %b want 0", game_over); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_start();
    pulse(M_PROG | M_TICK | M_LVL | M_FIN);
    n_cmp++; if (prog !== 5'd0) begin n_bad++; $display("FAIL idle_ignore_prog got %0d want 0", prog); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL idle_ignore_level got %0d want 0", level); end
    stb = ~M_START;
    step();
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL start_level got %0d want 1", level); end
    n_cmp++; if (prog !== 5'd0) begin n_bad++; $display("FAIL start_prog got %0d want 0", prog); end
    step();
    step();
    stb = '1;
    step();
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL start_held_level got %0d want 1", level); end
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL start_t0 got %b want 1", t0_n); end
  endtask

  task automatic test_prescaler();
    pulses(M_TICK, 3);
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL tick3_t0 got %b want 1", t0_n); end
    pulse(M_TICK);
    n_cmp++; if (t0_n !== 1'b0) begin n_bad++; $display("FAIL tick4_t0 got %b want 0", t0_n); end
    pulse(M_TICK);
    n_cmp++; if (t0_n !== 1'b0) begin n_bad++; $display("FAIL tick_sat_t0 got %b want 0", t0_n); end
    pulse(M_PROG);
    n_cmp++; if (prog !== 5'd1) begin n_bad++; $display("FAIL prog1 got %0d want 1", prog); end
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL prog_clears_t0 got %b want 1", t0_n); end
    // A tick held low for five cycles is a single event; two more pulses reach 3.
    stb = ~M_TICK;
    for (int unsigned i = 0; i < 5; i++) step();
    stb = '1;
    step();
    pulses(M_TICK, 2);
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL held_tick_t0 got %b want 1", t0_n); end
    pulse(M_TICK);
    n_cmp++; if (t0_n !== 1'b0) begin n_bad++; $display("FAIL held_tick_term_t0 got %b want 0", t0_n); end
    pulse(M_TICK | M_PROG);
    n_cmp++; if (prog !== 5'd2) begin n_bad++; $display("FAIL tick_prog_prog got %0d want 2", prog); end
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL tick_prog_t0 got %b want 1", t0_n); end
    pulses(M_TICK, 3);
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL tick_discard_t0 got %b want 1", t0_n); end
    pulse(M_TICK);
    n_cmp++; if (t0_n !== 1'b0) begin n_bad++; $display("FAIL tick_recount_t0 got %b want 0", t0_n); end
  endtask

  task automatic test_level_finish();
    pulses(M_PROG, 13);
    n_cmp++; if (prog !== 5'd15) begin n_bad++; $display("FAIL prog15 got %0d want 15", prog); end
    pulse(M_LVL);
    n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL level2 got %0d want 2", level); end
    n_cmp++; if (prog !== 5'd0) begin n_bad++; $display("FAIL level2_prog got %0d want 0", prog); end
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL level2_t0 got %b want 1", t0_n); end
  endtask

  task automatic test_simultaneous();
    pulses(M_PROG, 10);
    n_cmp++; if (prog !== 5'd10) begin n_bad++; $display("FAIL prog10 got %0d want 10", prog); end
    pulse(M_LVL | M_PROG);
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL lvl_prog_level got %0d want 3", level); end
    n_cmp++; if (prog !== 5'd0) begin n_bad++; $display("FAIL lvl_prog_prog got %0d want 0", prog); end
  endtask

  task automatic test_progress_saturation();
    pulses(M_PROG, 33);
    n_cmp++; if (prog !== 5'd31) begin n_bad++; $display("FAIL prog_sat got %0d want 31", prog); end
  endtask

  task automatic test_level_saturation_and_over();
    pulses(M_LVL, 4);
    n_cmp++; if (level !== 3'd7) begin n_bad++; $display("FAIL level7 got %0d want 7", level); end
    pulse(M_LVL);
    n_cmp++; if (level !== 3'd7) begin n_bad++; $display("FAIL level_sat got %0d want 7", level); end
    pulses(M_PROG, 2);
    pulse(M_FIN | M_LVL | M_PROG);
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL over_flag got %b want 1", game_over); end
    n_cmp++; if (level !== 3'd7) begin n_bad++; $display("FAIL over_level got %0d want 7", level); end
    n_cmp++; if (prog !== 5'd2) begin n_bad++; $display("FAIL over_prog got %0d want 2", prog); end
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL over_t0 got %b want 1", t0_n); end
    pulse(M_PROG);
    pulse(M_LVL);
    pulse(M_START);
    pulses(M_TICK, 4);
    n_cmp++; if (level !== 3'd7) begin n_bad++; $display("FAIL over_ignore_level got %0d want 7", level); end
    n_cmp++; if (prog !== 5'd2) begin n_bad++; $display("FAIL over_ignore_prog got %0d want 2", prog); end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL over_ignore_flag got %b want 1", game_over); end
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL over_ignore_t0 got %b want 1", t0_n); end
  endtask

  task automatic test_reset_in_over();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    pulse(M_START);
    pulses(M_PROG, 3);
    pulses(M_LVL, 4);
    pulse(M_FIN);
    n_cmp++; if (level !== 3'd5) begin n_bad++; $display("FAIL pre_reset_level got %0d want 5", level); end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL pre_reset_over got %b want 1", game_over); end
    // Asynchronous: assert mid-cycle and check before the next rising edge.
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL async_level got %0d want 0", level); end
    n_cmp++; if (prog !== 5'd0) begin n_bad++; $display("FAIL async_prog got %0d want 0", prog); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL async_over got %b want 0", game_over); end
    n_cmp++; if (t0_n !== 1'b1) begin n_bad++; $display("FAIL async_t0 got %b want 1", t0_n); end
    stb = ~M_START;
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL start_low_at_release got %0d want 1", level); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL release_over got %b want 0", game_over); end
    stb = '1;
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_prescaler();
    test_level_finish();
    test_simultaneous();
    test_progress_saturation();
    test_level_saturation_and_over();
    test_reset_in_over();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
